// File: rtl/mmcm_lock_sequencer.sv
// mmcm_lock_sequencer
// Drives the MMCM reset pulse, waits for a lock that stays stable, then
// releases three downstream reset domains one after another. If the lock
// never arrives, the MMCM is reset again and the attempt is counted. If the
// lock drops after release has started, every domain is reset at once and
// the whole sequence starts over.

module mmcm_lock_sequencer #(
    parameter int MMCM_RST_CYCLES    = 4,
    parameter int LOCK_TIMEOUT       = 1000,
    parameter int LOCK_STABLE_CYCLES = 64,
    parameter int RELEASE_GAP        = 8
) (
    input  logic       clk_in1,
    input  logic       reset,
    input  logic       locked_in,
    output logic       mmcm_reset,
    output logic [2:0] rst_out,
    output logic       ready,
    output logic [7:0] retry_count,
    output logic       lock_loss
);

    localparam logic [2:0] S_MMCM_RST  = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_STABLE    = 3'd2;
    localparam logic [2:0] S_RELEASE   = 3'd3;
    localparam logic [2:0] S_RUN       = 3'd4;

    // Every phase ends when the counter reaches its length minus one,
    // because the counter is cleared on the clock the phase is entered.
    localparam logic [15:0] RST_LAST     = 16'(MMCM_RST_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] STABLE_LAST  = 16'(LOCK_STABLE_CYCLES - 1);
    localparam logic [15:0] GAP_LAST     = 16'(RELEASE_GAP - 1);

    logic [2:0]  state;
    logic [15:0] count;
    logic        lock_meta;
    logic        lock_s;

    // Two-flop synchronizer bringing the asynchronous lock into clk_in1.
    always_ff @(posedge clk_in1) begin
        if (reset) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= locked_in;
            lock_s    <= lock_meta;
        end
    end

    // Sequencer: state, shared phase counter and all registered outputs.
    // The two release gaps reuse the same counter; rst_out[1] tells which
    // gap is running so the counter never has to span both of them.
    always_ff @(posedge clk_in1) begin
        if (reset) begin
            state       <= S_MMCM_RST;
            count       <= 16'd0;
            mmcm_reset  <= 1'b1;
            rst_out     <= 3'b111;
            ready       <= 1'b0;
            retry_count <= 8'd0;
            lock_loss   <= 1'b0;
        end else begin
            case (state)
                S_MMCM_RST: begin
                    rst_out <= 3'b111;
                    ready   <= 1'b0;
                    if (count == RST_LAST) begin
                        state      <= S_WAIT_LOCK;
                        count      <= 16'd0;
                        mmcm_reset <= 1'b0;
                    end else begin
                        count <= count + 16'd1;
                    end
                end

                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        state <= S_STABLE;
                        count <= 16'd0;
                    end else if (count == TIMEOUT_LAST) begin
                        state      <= S_MMCM_RST;
                        count      <= 16'd0;
                        mmcm_reset <= 1'b1;
                        if (retry_count != 8'hFF) begin
                            retry_count <= retry_count + 8'd1;
                        end
                    end else begin
                        count <= count + 16'd1;
                    end
                end

                S_STABLE: begin
                    if (!lock_s) begin
                        state <= S_WAIT_LOCK;
                        count <= 16'd0;
                    end else if (count == STABLE_LAST) begin
                        state   <= S_RELEASE;
                        count   <= 16'd0;
                        rst_out <= 3'b110;
                    end else begin
                        count <= count + 16'd1;
                    end
                end

                S_RELEASE: begin
                    if (!lock_s) begin
                        state      <= S_MMCM_RST;
                        count      <= 16'd0;
                        mmcm_reset <= 1'b1;
                        rst_out    <= 3'b111;
                        ready      <= 1'b0;
                        lock_loss  <= 1'b1;
                    end else if (count == GAP_LAST) begin
                        count <= 16'd0;
                        if (rst_out[1]) begin
                            rst_out <= 3'b100;
                        end else begin
                            rst_out <= 3'b000;
                            ready   <= 1'b1;
                            state   <= S_RUN;
                        end
                    end else begin
                        count <= count + 16'd1;
                    end
                end

                S_RUN: begin
                    if (!lock_s) begin
                        state      <= S_MMCM_RST;
                        count      <= 16'd0;
                        mmcm_reset <= 1'b1;
                        rst_out    <= 3'b111;
                        ready      <= 1'b0;
                        lock_loss  <= 1'b1;
                    end
                end

                default: begin
                    state      <= S_MMCM_RST;
                    count      <= 16'd0;
                    mmcm_reset <= 1'b1;
                    rst_out    <= 3'b111;
                    ready      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmcm_lock_sequencer.sv
// tb_mmcm_lock_sequencer
// Directed scenarios with hand-derived timing plus a randomized lock pattern,
// all checked cycle by cycle against a timestamp-based behavioural model.

module tb_mmcm_lock_sequencer;

    localparam int MRC = 4;
    localparam int TO  = 16;
    localparam int STB = 8;
    localparam int GAP = 2;

    logic       clk_in1 = 1'b0;
    logic       reset;
    logic       locked_in;
    logic       mmcm_reset;
    logic [2:0] rst_out;
    logic       ready;
    logic [7:0] retry_count;
    logic       lock_loss;

    int checks = 0;
    int errors = 0;

    mmcm_lock_sequencer #(
        .MMCM_RST_CYCLES   (MRC),
        .LOCK_TIMEOUT      (TO),
        .LOCK_STABLE_CYCLES(STB),
        .RELEASE_GAP       (GAP)
    ) dut (
        .clk_in1    (clk_in1),
        .reset      (reset),
        .locked_in  (locked_in),
        .mmcm_reset (mmcm_reset),
        .rst_out    (rst_out),
        .ready      (ready),
        .retry_count(retry_count),
        .lock_loss  (lock_loss)
    );

    // 20 ns clock: rising edges at 10, 30, 50 ... and falling edges on multiples of 20.
    always #10 clk_in1 = ~clk_in1;

    // ---------------- behavioural model ----------------
    typedef enum int {M_RST, M_WAIT, M_STABLE, M_REL, M_RUN} mphase_t;

    mphase_t    mPhase = M_RST;
    int         edgeNo = 0;
    int         mEntry = 0;
    bit         mS1 = 1'b0;
    bit         mS2 = 1'b0;
    int         mRetry = 0;
    bit         mLoss = 1'b0;
    bit         modelValid = 1'b0;
    bit         expMmcm;
    logic [2:0] expRst;
    bit         expReady;

    // One model step per rising edge; phases are tracked by the edge at which
    // they were entered, and outputs are derived from elapsed time.
    task automatic modelStep();
        bit ls;
        int el;
        edgeNo++;
        ls = mS2;
        if (reset) begin
            mPhase = M_RST;
            mEntry = edgeNo;
            mRetry = 0;
            mLoss = 1'b0;
            mS1 = 1'b0;
            mS2 = 1'b0;
            modelValid = 1'b1;
        end else begin
            el = edgeNo - mEntry;
            case (mPhase)
                M_RST: if (el == MRC) begin mPhase = M_WAIT; mEntry = edgeNo; end
                M_WAIT: begin
                    if (ls) begin
                        mPhase = M_STABLE; mEntry = edgeNo;
                    end else if (el == TO) begin
                        mPhase = M_RST; mEntry = edgeNo;
                        mRetry = (mRetry < 255) ? mRetry + 1 : 255;
                    end
                end
                M_STABLE: begin
                    if (!ls) begin
                        mPhase = M_WAIT; mEntry = edgeNo;
                    end else if (el == STB) begin
                        mPhase = M_REL; mEntry = edgeNo;
                    end
                end
                M_REL, M_RUN: begin
                    if (!ls) begin
                        mPhase = M_RST; mEntry = edgeNo; mLoss = 1'b1;
                    end else if (mPhase == M_REL && el == 2 * GAP) begin
                        mPhase = M_RUN; mEntry = edgeNo;
                    end
                end
                default: mPhase = M_RST;
            endcase
            mS2 = mS1;
            mS1 = locked_in;
        end
        expMmcm  = (mPhase == M_RST);
        expReady = (mPhase == M_RUN);
        case (mPhase)
            M_REL:   expRst = 3'b111 << (1 + (edgeNo - mEntry) / GAP);
            M_RUN:   expRst = 3'b000;
            default: expRst = 3'b111;
        endcase
    endtask

    initial begin
        forever begin
            @(posedge clk_in1);
            modelStep();
        end
    end

    // ---------------- checking ----------------
    task automatic expectValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    task automatic checkOutput();
        expectValue("mmcm_reset",  32'(mmcm_reset),  32'(expMmcm));
        expectValue("rst_out",     32'(rst_out),     32'(expRst));
        expectValue("ready",       32'(ready),       32'(expReady));
        expectValue("retry_count", 32'(retry_count), 32'(mRetry));
        expectValue("lock_loss",   32'(lock_loss),   32'(mLoss));
    endtask

    // Compare the DUT against the model on every falling edge.
    initial begin
        @(posedge clk_in1);
        forever begin
            @(negedge clk_in1);
            if (modelValid) checkOutput();
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic applyStimulus(input int cycles);
        repeat (cycles) @(negedge clk_in1);
    endtask

    task automatic resetPulse(input int cycles);
        @(negedge clk_in1);
        reset = 1'b1;
        repeat (cycles) @(negedge clk_in1);
        reset = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        expectValue({tag, " mmcm_reset"},  32'(mmcm_reset),  32'd1);
        expectValue({tag, " rst_out"},     32'(rst_out),     32'd7);
        expectValue({tag, " ready"},       32'(ready),       32'd0);
        expectValue({tag, " retry_count"}, 32'(retry_count), 32'd0);
        expectValue({tag, " lock_loss"},   32'(lock_loss),   32'd0);
    endtask

    // Step falling edges from the current one, noting when mmcm_reset first
    // drops and when each rst_out pattern first appears; locked_in may be
    // changed at two chosen falling edges.
    task automatic watchSequence(input int maxCycles, input int chgA, input bit valA,
                                 input int chgB, input bit valB,
                                 output int tLow, output int t110, output int t100, output int t000);
        tLow = -1; t110 = -1; t100 = -1; t000 = -1;
        for (int k = 1; k <= maxCycles; k++) begin
            @(negedge clk_in1);
            if (mmcm_reset === 1'b0 && tLow < 0) tLow = k;
            if (rst_out === 3'b110 && t110 < 0) t110 = k;
            if (rst_out === 3'b100 && t100 < 0) t100 = k;
            if (rst_out === 3'b000 && t000 < 0) t000 = k;
            if (k == chgA) locked_in = valA;
            if (k == chgB) locked_in = valB;
        end
    endtask

    task automatic waitForRst(input logic [2:0] target, input int maxCycles, output bit found);
        found = 1'b0;
        for (int k = 0; k < maxCycles && !found; k++) begin
            @(negedge clk_in1);
            if (rst_out === target) found = 1'b1;
        end
    endtask

    task automatic waitForReady(input int maxCycles, output bit found);
        found = 1'b0;
        for (int k = 0; k < maxCycles && !found; k++) begin
            @(negedge clk_in1);
            if (ready === 1'b1) found = 1'b1;
        end
    endtask

    // ---------------- directed and random scenarios ----------------
    initial begin
        int  tLow, t110, t100, t000, tHit;
        bit  found;
        bit  hitReady, hitLoss, hitMmcm;
        int  holdLeft;

        reset = 1'b1;
        locked_in = 1'b1;

        // Normal start: reset released at 100 ns with lock present throughout.
        applyStimulus(5);
        reset = 1'b0;
        checkResetValues("reset state");
        watchSequence(30, -1, 1'b0, -1, 1'b0, tLow, t110, t100, t000);
        expectValue("normal mmcm low at", 32'(tLow), 32'd4);
        expectValue("normal 110 at", 32'(t110), 32'd13);
        expectValue("normal 100 at", 32'(t100), 32'd15);
        expectValue("normal 000 at", 32'(t000), 32'd17);
        expectValue("normal ready", 32'(ready), 32'd1);
        expectValue("normal retry", 32'(retry_count), 32'd0);

        // One-clock lock glitch after five stable clocks restarts the wait.
        resetPulse(2);
        watchSequence(40, 8, 1'b0, 9, 1'b1, tLow, t110, t100, t000);
        expectValue("glitch mmcm low at", 32'(tLow), 32'd4);
        expectValue("glitch 110 at", 32'(t110), 32'd20);
        expectValue("glitch 100 at", 32'(t100), 32'd22);
        expectValue("glitch 000 at", 32'(t000), 32'd24);
        expectValue("glitch lock_loss", 32'(lock_loss), 32'd0);

        // Lock loss while running: full reset three clocks after the drop.
        applyStimulus(5);
        locked_in = 1'b0;
        tHit = -1; hitReady = 1'b1; hitLoss = 1'b0; hitMmcm = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk_in1);
            if (rst_out === 3'b111 && tHit < 0) begin
                tHit = k; hitReady = ready; hitLoss = lock_loss; hitMmcm = mmcm_reset;
            end
            if (k == 3) locked_in = 1'b1;
        end
        expectValue("loss latency", 32'(tHit), 32'd3);
        expectValue("loss ready", 32'(hitReady), 32'd0);
        expectValue("loss flag", 32'(hitLoss), 32'd1);
        expectValue("loss mmcm_reset", 32'(hitMmcm), 32'd1);
        waitForReady(80, found);
        expectValue("loss resequence ready", 32'(found), 32'd1);
        expectValue("loss flag sticky", 32'(lock_loss), 32'd1);
        expectValue("loss no retry", 32'(retry_count), 32'd0);

        // Reset in the middle of release clears everything, including lock_loss.
        locked_in = 1'b0;
        applyStimulus(2);
        locked_in = 1'b1;
        waitForRst(3'b110, 80, found);
        expectValue("midrelease found 110", 32'(found), 32'd1);
        reset = 1'b1;
        applyStimulus(1);
        checkResetValues("midrelease");
        reset = 1'b0;
        watchSequence(30, -1, 1'b0, -1, 1'b0, tLow, t110, t100, t000);
        expectValue("restart mmcm low at", 32'(tLow), 32'd4);
        expectValue("restart 000 at", 32'(t000), 32'd17);

        // Lock arrives exactly on the timeout clock: lock wins, no retry.
        locked_in = 1'b0;
        resetPulse(2);
        watchSequence(40, 17, 1'b1, -1, 1'b0, tLow, t110, t100, t000);
        expectValue("coincide mmcm low at", 32'(tLow), 32'd4);
        expectValue("coincide 110 at", 32'(t110), 32'd28);
        expectValue("coincide retry", 32'(retry_count), 32'd0);

        // Never locks: retry every 20 clocks, saturating at 255.
        locked_in = 1'b0;
        resetPulse(2);
        applyStimulus(100);
        expectValue("nolock retry at 100", 32'(retry_count), 32'd5);
        expectValue("nolock mmcm at 100", 32'(mmcm_reset), 32'd1);
        applyStimulus(4999);
        expectValue("nolock retry at 5099", 32'(retry_count), 32'd254);
        applyStimulus(1);
        expectValue("nolock retry at 5100", 32'(retry_count), 32'd255);
        applyStimulus(400);
        expectValue("nolock retry saturated", 32'(retry_count), 32'd255);
        expectValue("nolock lock_loss", 32'(lock_loss), 32'd0);

        // Random lock pattern with occasional resets, checked by the model.
        locked_in = 1'b1;
        resetPulse(1);
        holdLeft = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk_in1);
            if (reset) begin
                reset = 1'b0;
            end else if ($urandom_range(0, 499) == 0) begin
                reset = 1'b1;
            end
            if (holdLeft == 0) begin
                locked_in = ($urandom_range(0, 99) < 70);
                holdLeft = locked_in ? $urandom_range(1, 80) : $urandom_range(1, 25);
            end else begin
                holdLeft--;
            end
        end
        reset = 1'b0;
        applyStimulus(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmcm_lock_sequencer.md
MMCM_LOCK_SEQUENCER -- requirements
Module: mmcm_lock_sequencer

Interface
REQ-001 The block SHALL run on one clock; reset is synchronous and active-high.
REQ-002 The block SHALL have these parameters:
- MMCM_RST_CYCLES, 4, mmcm_reset pulse length in clocks.
- LOCK_TIMEOUT, 1000, clocks allowed in WAIT_LOCK before a retry.
- LOCK_STABLE_CYCLES, 64, consecutive synchronized-lock clocks required before release.
- RELEASE_GAP, 8, clocks between successive rst_out bit releases.
- All parameters SHALL be in the range 1..65535.
REQ-003 The block SHALL have these ports:
- clk_in1, input, 1, free-running input clock (same source that feeds the MMCM).
- reset, input, 1, synchronous active-high reset.
- locked_in, input, 1, MMCM locked, asynchronous to clk_in1.
- mmcm_reset, output, 1, reset request to the MMCM.
- rst_out, output, 3, active-high reset per downstream clock domain.
- ready, output, 1, all domains released and lock present.
- retry_count, output, 8, lock-timeout retries, saturating.
- lock_loss, output, 1, sticky flag: lock dropped after release began.

Function
REQ-004 locked_in SHALL pass through a 2-flop synchronizer; all FSM decisions SHALL use the synchronized value lock_s.
REQ-005 The FSM SHALL have states MMCM_RST, WAIT_LOCK, STABLE, RELEASE, RUN, driven by one 16-bit cycle counter.
REQ-006 All outputs SHALL be registered.
REQ-007 MMCM_RST behaviour:
- mmcm_reset=1 and rst_out=3'b111.
- After exactly MMCM_RST_CYCLES clocks, go to WAIT_LOCK with the counter cleared.
REQ-008 WAIT_LOCK behaviour:
- mmcm_reset=0.
- If lock_s=1, go to STABLE with the counter cleared.
- Otherwise, after LOCK_TIMEOUT clocks, go to MMCM_RST and increment retry_count, saturating at 255.
REQ-009 STABLE behaviour:
- If lock_s=0 on any cycle, go to WAIT_LOCK with the counter cleared; the timeout restarts.
- After LOCK_STABLE_CYCLES consecutive lock_s=1 clocks, go to RELEASE.
REQ-010 RELEASE behaviour:
- Deassert rst_out[0] on entry.
- Deassert rst_out[1] RELEASE_GAP clocks later.
- Deassert rst_out[2] another RELEASE_GAP clocks later.
- Go to RUN on the clock rst_out[2] deasserts.
REQ-011 ready SHALL be 1 only in RUN; ready rises on the same clock rst_out[2] falls.
REQ-012 Lock loss in RELEASE or RUN (lock_s=0) SHALL, on the next clock:
- assert rst_out=3'b111, with all bits asserted together;
- drive ready=0;
- set lock_loss=1;
- enter MMCM_RST.
REQ-013 lock_loss SHALL clear only on reset; retry_count SHALL NOT increment on lock loss, only on timeout.
REQ-014 If a timeout and lock_s rising coincide in WAIT_LOCK, lock SHALL win and the FSM goes to STABLE.
REQ-015 rst_out bits SHALL only deassert in the order 0, 1, 2 and SHALL never deassert outside RELEASE/RUN.

Reset
REQ-016 reset SHALL take priority over all FSM activity, including mid-RELEASE and mid-RUN.
REQ-017 Values while reset=1 and on the clock after it falls:
- state=MMCM_RST, counter=0.
- mmcm_reset=1, rst_out=3'b111, ready=0.
- retry_count=0, lock_loss=0.
- synchronizer flops=0.

Verification
REQ-018 Bench parameters SHALL be MMCM_RST_CYCLES=4, LOCK_TIMEOUT=16, LOCK_STABLE_CYCLES=8, RELEASE_GAP=2, clk_in1 period 20 ns.
REQ-019 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Normal start: locked_in=1 from t=0, reset released at 100 ns -> mmcm_reset high for 4 clocks, then rst_out goes 111->110->100->000 at 2-clock spacing, ready=1, retry_count=0.
- Never locks: locked_in=0 -> mmcm_reset pulses 4 clocks every 20 clocks; retry_count increments per pulse and holds at 255 after 255 retries.
- Glitch in STABLE: locked_in low for 1 clock after 5 stable clocks -> return to WAIT_LOCK, ready stays 0, lock_loss=0, release only after 8 fresh consecutive lock clocks.
- Loss in RUN: locked_in drops while ready=1 -> within 3 clocks of the drop, rst_out=111, ready=0, lock_loss=1, mmcm_reset=1; full re-sequence follows once lock returns; lock_loss stays 1.
- Reset mid-RELEASE: assert reset when rst_out=110 -> all REQ-017 values on the next clock; the sequence restarts from MMCM_RST.
- Coincidence: lock_s rises on the timeout clock -> STABLE entered, retry_count unchanged.
